fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, the PC loaded on reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Alt_PC  input  32  redirect target from decode.
REQ-005 SHALL have port Request_Alt_PC  input  1  redirect strobe from decode.
REQ-006 SHALL have port WANT_FREEZE  input  1  decode request to stop issuing fetches.
REQ-007 SHALL have port halt  input  1  decode queue full; decode cannot accept this cycle.
REQ-008 SHALL have port imem_req  output  1  instruction memory read strobe, one-cycle pulse.
REQ-009 SHALL have port imem_addr  output  32  read address; 0 when imem_req=0.
REQ-010 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-011 SHALL have port imem_valid  input  1  imem_rdata valid; earliest one cycle after imem_req.
REQ-012 SHALL have port instr1_out  output  32  instruction to decode; 0 is a bubble/NOP.
REQ-013 SHALL have port instr_pc_out  output  32  PC of instr1_out.
REQ-014 SHALL have port instr_pc_plus4_out  output  32  instr_pc_out+4.
REQ-015 SHALL have port fetch_count  output  32  count of instructions delivered.

Function
REQ-016 SHALL implement FSM states S_REQ, S_WAIT, S_HOLD, S_FREEZE, all registered.
REQ-017 S_REQ: imem_req=1, imem_addr=PC for exactly one cycle; next S_WAIT. If WANT_FREEZE=1, no request; next S_FREEZE.
REQ-018 S_WAIT, imem_valid=1, halt=0: next edge drive {instr1_out, instr_pc_out, instr_pc_plus4_out} = {imem_rdata, PC, PC+4}; PC<=PC+4; fetch_count+1; next S_REQ.
REQ-019 S_WAIT, imem_valid=1, halt=1: capture rdata into a one-entry hold register; outputs 0; next S_HOLD.
REQ-020 S_HOLD: while halt=1, outputs 0 and no request; first cycle halt=0, deliver held word as in REQ-018; next S_REQ.
REQ-021 S_FREEZE: no requests while WANT_FREEZE=1; next S_REQ the cycle after it deasserts. An outstanding response is still delivered before freezing.
REQ-022 Delivered outputs SHALL be valid for exactly one cycle; in every other cycle all three are 0.
REQ-023 PC+4 and fetch_count SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-024 Request_Alt_PC=1 SHALL take priority over imem_valid, halt and WANT_FREEZE, in any state: PC<=Alt_PC; hold register cleared; outputs 0 next cycle; no delivery.
REQ-025 Redirect with a request outstanding SHALL set a kill flag. The response for that request is discarded and clears the flag. The state then goes to S_REQ for Alt_PC.
REQ-026 Redirect with no request outstanding SHALL go to S_REQ next cycle.
REQ-027 Redirect in the same cycle as imem_valid SHALL discard that response.
REQ-028 imem_valid while no request is outstanding SHALL be ignored.
REQ-029 At most one request SHALL be outstanding; throughput is at most one instruction per two cycles.

Reset
REQ-030 RESET=0 SHALL immediately force: PC=RESET_PC; state S_REQ; kill flag and hold register cleared; imem_req=0; imem_addr=0; instr1_out, instr_pc_out, instr_pc_plus4_out=0; fetch_count=0.
REQ-031 Reset mid-request SHALL abandon the request; a late imem_valid after release is ignored per REQ-028.
REQ-032 The first request SHALL issue in the first cycle after RESET deasserts.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h24080005 -> imem_addr=32'h00400000. Two cycles later instr1_out=32'h24080005, instr_pc_out=32'h00400000, instr_pc_plus4_out=32'h00400004, fetch_count=1.
REQ-034 halt=1 for 3 cycles as a response arrives -> outputs stay 0 for 3 cycles. The held word is delivered the cycle after halt drops, and no word is lost or duplicated.
REQ-035 Request_Alt_PC=1, Alt_PC=32'h00400100, while a request to 32'h00400008 is outstanding -> that response is discarded. The next imem_addr=32'h00400100 and the next delivered instr_pc_out=32'h00400100.
REQ-036 WANT_FREEZE=1 for 5 cycles -> imem_req=0 throughout after any outstanding delivery. Fetch resumes at the next sequential PC.
REQ-037 PC=32'hFFFFFFFC delivered -> instr_pc_plus4_out=0 and the next imem_addr=0.
REQ-038 Assert RESET during S_WAIT, then imem_valid after release -> the stale response is ignored; the fetch restarts at RESET_PC with fetch_count=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: decode-side control, instruction-memory read port and delivered instruction.
// The master modport is the fetch unit's view; the slave modport is the decode/memory side.
interface fetch_unit_if;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC;
  logic        WANT_FREEZE;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr1_out;
  logic [31:0] instr_pc_out;
  logic [31:0] instr_pc_plus4_out;
  logic [31:0] fetch_count;

  modport master (
    input  Alt_PC, Request_Alt_PC, WANT_FREEZE, halt, imem_rdata, imem_valid,
    output imem_req, imem_addr, instr1_out, instr_pc_out, instr_pc_plus4_out, fetch_count
  );

  modport slave (
    output Alt_PC, Request_Alt_PC, WANT_FREEZE, halt, imem_rdata, imem_valid,
    input  imem_req, imem_addr, instr1_out, instr_pc_out, instr_pc_plus4_out, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, one-entry hold buffer while decode stalls,
// redirect with kill of an in-flight response; delivered word appears one cycle after imem_valid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FREEZE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] count_q, count_d;

  logic        issue;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_d       = hold_q;
    issue        = 1'b0;
    deliver      = 1'b0;
    deliver_word = '0;

    if (bus.Request_Alt_PC) begin
      pc_d   = bus.Alt_PC;
      hold_d = '0;
      // An in-flight read that has not returned yet must be swallowed before refetching.
      if (state_q == S_WAIT && !bus.imem_valid) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.WANT_FREEZE) begin
            state_d = S_FREEZE;
          end else begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (bus.halt) begin
              hold_d  = bus.imem_rdata;
              state_d = S_HOLD;
            end else begin
              deliver      = 1'b1;
              deliver_word = bus.imem_rdata;
              pc_d         = pc_plus4;
              state_d      = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!bus.halt) begin
            deliver      = 1'b1;
            deliver_word = hold_q;
            hold_d       = '0;
            pc_d         = pc_plus4;
            state_d      = S_REQ;
          end
        end
        S_FREEZE: begin
          if (!bus.WANT_FREEZE) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Delivery registers are zero in every cycle that does not carry an instruction.
  always_comb begin
    instr_d = '0;
    ipc_d   = '0;
    ipc4_d  = '0;
    count_d = count_q;
    if (deliver) begin
      instr_d = deliver_word;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      count_q <= count_d;
    end
  end

  // The strobe is combinational from S_REQ so the first read leaves right after reset release;
  // gating with RESET keeps it low while reset is held.
  assign bus.imem_req           = issue & RESET;
  assign bus.imem_addr          = bus.imem_req ? pc_q : 32'd0;
  assign bus.instr1_out         = instr_q;
  assign bus.instr_pc_out       = ipc_q;
  assign bus.instr_pc_plus4_out = ipc4_q;
  assign bus.fetch_count        = count_q;

  a_single_outstanding: assert property (
    @(posedge CLK) disable iff (!RESET) bus.imem_req |=> !bus.imem_req);

  a_kill_only_waiting: assert property (
    @(posedge CLK) disable iff (!RESET) kill_q |-> (state_q == S_WAIT));

endmodule
